// File: rtl/fim_ram_1r1w_init.sv
// fim_ram_1r1w_init: simple dual-port RAM (1 write, 1 read) with byte enables,
// per-byte even parity, self-initialisation after reset, optional write-to-read
// forwarding, and sticky parity-error tracking.
module fim_ram_1r1w_init #(
  parameter int DEPTH          = 6,
  parameter int WIDTH          = 64,
  parameter int READ_LATENCY   = 2,
  parameter int INCLUDE_PARITY = 1,
  parameter int BYPASS         = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [DEPTH-1:0]     waddr,
  input  logic [WIDTH-1:0]     din,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic                 err_inj,
  input  logic                 re,
  input  logic [DEPTH-1:0]     raddr,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 perr,
  output logic [DEPTH-1:0]     perr_addr,
  output logic [15:0]          perr_cnt,
  input  logic                 perr_clr,
  output logic                 init_done
);

  localparam int NB      = WIDTH / 8;
  localparam int ENTRIES = 1 << DEPTH;

  if ((WIDTH % 8) != 0) begin : g_width_chk
    $error("fim_ram_1r1w_init: WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_lat_chk
    $error("fim_ram_1r1w_init: READ_LATENCY must be 1 or 2");
  end

  // Even parity, one bit per byte.
  function automatic logic [NB-1:0] calc_par(input logic [WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] init_cnt_q, init_cnt_d;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [NB-1:0]    par_q [ENTRIES];

  logic             ready;
  logic             wr_en;
  logic [DEPTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [NB-1:0]    wr_be;
  logic [NB-1:0]    wr_par;

  logic             rd_fire;
  logic [WIDTH-1:0] rd_word;
  logic [NB-1:0]    rd_par;

  logic             vld_p0_q, vld_p0_d;
  logic [WIDTH-1:0] rd_data_p0_q, rd_data_p0_d;
  logic [NB-1:0]    rd_par_p0_q, rd_par_p0_d;
  logic [DEPTH-1:0] rd_addr_p0_q, rd_addr_p0_d;

  logic             src_vld;
  logic [WIDTH-1:0] src_data;
  logic [NB-1:0]    src_par;
  logic [DEPTH-1:0] src_addr;
  logic             src_perr;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             perr_q, perr_d;
  logic [15:0]      perr_cnt_q, perr_cnt_d, cnt_base;
  logic [DEPTH-1:0] perr_addr_q, perr_addr_d, addr_base;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  // Init sequencer: walk every address once, then stay READY until reset.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {DEPTH{1'b1}}) state_d = ST_READY;
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
  end

  // Sequencer state register; reset restarts initialisation from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Write port mux: init sequencer owns the port until READY; user writes are
  // ignored before then. err_inj flips the parity of the enabled bytes.
  always_comb begin
    if (!ready) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt_q;
      wr_data = INIT_VALUE;
      wr_be   = '1;
      wr_par  = calc_par(INIT_VALUE);
    end else begin
      wr_en   = we && (|wbe);
      wr_addr = waddr;
      wr_data = din;
      wr_be   = wbe;
      wr_par  = calc_par(din) ^ {NB{err_inj}};
    end
  end

  // Storage array: byte-granular data and parity update.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          par_q[wr_addr][i]        <= wr_par[i];
        end
      end
    end
  end

  // Array read with optional forwarding of bytes being written this cycle.
  always_comb begin
    rd_fire = re && ready;
    rd_word = mem_q[raddr];
    rd_par  = par_q[raddr];
    if ((BYPASS != 0) && ready && we && (waddr == raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          rd_word[8*i +: 8] = din[8*i +: 8];
          rd_par[i]         = wr_par[i];
        end
      end
    end
  end

  // Stage p0 next-state: capture read word, parity and address on a read.
  always_comb begin
    vld_p0_d     = rd_fire;
    rd_data_p0_d = rd_fire ? rd_word : rd_data_p0_q;
    rd_par_p0_d  = rd_fire ? rd_par  : rd_par_p0_q;
    rd_addr_p0_d = rd_fire ? raddr   : rd_addr_p0_q;
  end

  // ---- stage p0: registered RAM output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0_q <= 1'b0;
    else        vld_p0_q <= vld_p0_d;
  end

  // Stage p0 data registers carry no reset; vld_p0 qualifies them.
  always_ff @(posedge clk) begin
    rd_data_p0_q <= rd_data_p0_d;
    rd_par_p0_q  <= rd_par_p0_d;
    rd_addr_p0_q <= rd_addr_p0_d;
  end

  // Output stage source: straight from the array for latency 1, else from p0.
  always_comb begin
    if (READ_LATENCY == 1) begin
      src_vld  = rd_fire;
      src_data = rd_word;
      src_par  = rd_par;
      src_addr = raddr;
    end else begin
      src_vld  = vld_p0_q;
      src_data = rd_data_p0_q;
      src_par  = rd_par_p0_q;
      src_addr = rd_addr_p0_q;
    end
    src_perr = (INCLUDE_PARITY != 0) && (|(src_par ^ calc_par(src_data)));
  end

  // Output and error-tracking next-state; clear applies before a same-cycle error.
  always_comb begin
    dout_d       = src_vld ? src_data : dout_q;
    dout_valid_d = src_vld;
    perr_d       = src_vld && src_perr;
    cnt_base     = perr_clr ? '0 : perr_cnt_q;
    addr_base    = perr_clr ? '0 : perr_addr_q;
    perr_cnt_d   = cnt_base;
    perr_addr_d  = addr_base;
    if (src_vld && src_perr) begin
      if (cnt_base == '0)      perr_addr_d = src_addr;
      if (cnt_base != 16'hFFFF) perr_cnt_d = cnt_base + 16'd1;
    end
  end

  // ---- output stage: dout / dout_valid / perr / error tracking ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      perr_q       <= 1'b0;
      perr_cnt_q   <= '0;
      perr_addr_q  <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      perr_q       <= perr_d;
      perr_cnt_q   <= perr_cnt_d;
      perr_addr_q  <= perr_addr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign perr       = perr_q;
  assign perr_cnt   = perr_cnt_q;
  assign perr_addr  = perr_addr_q;

endmodule

// File: tb/tb_fim_ram_1r1w_init.sv
// Directed bench for fim_ram_1r1w_init. Two instances share the stimulus:
// u_dut (READ_LATENCY=2, BYPASS=1) and u_dut1 (READ_LATENCY=1, BYPASS=0).
module tb_fim_ram_1r1w_init;

  localparam logic [63:0] IV = 64'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re, err_inj, perr_clr;
  logic [3:0]  waddr, raddr;
  logic [63:0] din;
  logic [7:0]  wbe;

  logic [63:0] dout, dout1;
  logic        dout_valid, dout_valid1, perr, perr1, init_done, init_done1;
  logic [3:0]  perr_addr, perr_addr1;
  logic [15:0] perr_cnt, perr_cnt1;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fim_ram_1r1w_init #(.DEPTH(4), .WIDTH(64), .READ_LATENCY(2), .INCLUDE_PARITY(1),
                      .BYPASS(1), .INIT_VALUE(IV)) u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .wbe(wbe),
    .err_inj(err_inj), .re(re), .raddr(raddr), .dout(dout), .dout_valid(dout_valid),
    .perr(perr), .perr_addr(perr_addr), .perr_cnt(perr_cnt), .perr_clr(perr_clr),
    .init_done(init_done));

  fim_ram_1r1w_init #(.DEPTH(4), .WIDTH(64), .READ_LATENCY(1), .INCLUDE_PARITY(1),
                      .BYPASS(0), .INIT_VALUE(IV)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .din(din), .wbe(wbe),
    .err_inj(err_inj), .re(re), .raddr(raddr), .dout(dout1), .dout_valid(dout_valid1),
    .perr(perr1), .perr_addr(perr_addr1), .perr_cnt(perr_cnt1), .perr_clr(perr_clr),
    .init_done(init_done1));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; when r is set, checks the latency-1 instance after
  // the sampling edge and the latency-2 instance one edge later.
  task automatic xfer(input logic w, input logic [3:0] wa, input logic [63:0] d,
                      input logic [7:0] be, input logic inj, input logic r,
                      input logic [3:0] ra, input logic [63:0] e2, input logic ep2,
                      input logic [63:0] e1, input logic ep1, input string tag);
    we = w; waddr = wa; din = d; wbe = be; err_inj = inj; re = r; raddr = ra;
    tick();
    we = 1'b0; re = 1'b0; err_inj = 1'b0; wbe = '0;
    if (r) begin
      check_eq({tag, "_vld1"},  dout_valid1, 1'b1);
      check_eq({tag, "_dout1"}, dout1, e1);
      check_eq({tag, "_perr1"}, perr1, ep1);
      check_eq({tag, "_vld2_early"}, dout_valid, 1'b0);
      tick();
      check_eq({tag, "_vld2"},  dout_valid, 1'b1);
      check_eq({tag, "_dout2"}, dout, e2);
      check_eq({tag, "_perr2"}, perr, ep2);
      check_eq({tag, "_vld1_off"}, dout_valid1, 1'b0);
    end
  endtask

  task automatic wait_init(output int cyc, output int vcnt);
    cyc = 0;
    vcnt = 0;
    while (!init_done && cyc < 100) begin
      tick();
      cyc++;
      vcnt += int'(dout_valid) + int'(dout_valid1);
    end
  endtask

  initial begin
    int cyc, vcnt;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; err_inj = 1'b0; perr_clr = 1'b0;
    waddr = '0; raddr = '0; din = '0; wbe = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_dout", dout, 64'h0);
    check_eq("rst_dout_valid", dout_valid, 1'b0);
    check_eq("rst_perr", perr, 1'b0);
    check_eq("rst_perr_cnt", perr_cnt, 16'h0);
    check_eq("rst_perr_addr", perr_addr, 4'h0);

    // Initialisation length
    rst_n = 1'b1;
    wait_init(cyc, vcnt);
    check_eq("init_cycles", cyc, 16);
    check_eq("init_done1", init_done1, 1'b1);

    // Every entry holds INIT_VALUE with clean parity
    for (int a = 0; a < 16; a++)
      xfer(0, 0, 0, 0, 0, 1, 4'(a), IV, 0, IV, 0, $sformatf("init_rd%0d", a));

    // Byte-enable write
    xfer(1, 3, 64'h1122334455667788, 8'h0F, 0, 0, 0, 0, 0, 0, 0, "bw_wr");
    xfer(0, 0, 0, 0, 0, 1, 3, 64'h0000000055667788, 0, 64'h0000000055667788, 0, "bw_rd");

    // Collision: forwarded upper bytes (BYPASS=1) vs old word (BYPASS=0)
    xfer(1, 5, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 0, 1, 5,
         64'hFFFFFFFF000000A5, 0, 64'h00000000000000A5, 0, "coll");
    xfer(0, 0, 0, 0, 0, 1, 5, 64'hFFFFFFFF000000A5, 0, 64'hFFFFFFFF000000A5, 0, "coll_after");

    // Error injection and tracking
    xfer(1, 7, 64'h12, 8'h01, 1, 0, 0, 0, 0, 0, 0, "inj7_wr");
    xfer(0, 0, 0, 0, 0, 1, 7, 64'h12, 1, 64'h12, 1, "inj7_rd_a");
    xfer(0, 0, 0, 0, 0, 1, 7, 64'h12, 1, 64'h12, 1, "inj7_rd_b");
    check_eq("cnt_after7", perr_cnt, 16'd2);
    check_eq("addr_after7", perr_addr, 4'd7);
    check_eq("cnt1_after7", perr_cnt1, 16'd2);
    check_eq("addr1_after7", perr_addr1, 4'd7);
    xfer(1, 9, 64'h34, 8'h01, 1, 0, 0, 0, 0, 0, 0, "inj9_wr");
    xfer(0, 0, 0, 0, 0, 1, 9, 64'h34, 1, 64'h34, 1, "inj9_rd");
    check_eq("cnt_after9", perr_cnt, 16'd3);
    check_eq("addr_after9", perr_addr, 4'd7);
    perr_clr = 1'b1; tick(); perr_clr = 1'b0;
    check_eq("clr_cnt", perr_cnt, 16'd0);
    check_eq("clr_addr", perr_addr, 4'd0);
    check_eq("clr_cnt1", perr_cnt1, 16'd0);
    check_eq("clr_addr1", perr_addr1, 4'd0);

    // Clear coincident with an error on the latency-2 instance only
    re = 1'b1; raddr = 9; tick(); re = 1'b0;
    perr_clr = 1'b1; tick(); perr_clr = 1'b0;
    check_eq("clrhit_perr", perr, 1'b1);
    check_eq("clrhit_cnt", perr_cnt, 16'd1);
    check_eq("clrhit_addr", perr_addr, 4'd9);
    check_eq("clrhit_cnt1", perr_cnt1, 16'd0);
    check_eq("clrhit_addr1", perr_addr1, 4'd0);

    // Forwarded bytes carry injected parity (BYPASS=1); old word is clean
    xfer(1, 10, 64'h56, 8'h01, 1, 1, 10, 64'h56, 1, IV, 0, "coll_inj");
    check_eq("collinj_cnt", perr_cnt, 16'd2);
    check_eq("collinj_addr", perr_addr, 4'd9);
    check_eq("collinj_cnt1", perr_cnt1, 16'd0);

    // Back-to-back reads: latency 1 vs latency 2
    xfer(1, 0, 64'h1000, 8'hFF, 0, 0, 0, 0, 0, 0, 0, "b2b_wr0");
    xfer(1, 1, 64'h2001, 8'hFF, 0, 0, 0, 0, 0, 0, 0, "b2b_wr1");
    xfer(1, 2, 64'h3002, 8'hFF, 0, 0, 0, 0, 0, 0, 0, "b2b_wr2");
    re = 1'b1; raddr = 0; tick();
    check_eq("b2b_t0_vld1", dout_valid1, 1'b1);
    check_eq("b2b_t0_dout1", dout1, 64'h1000);
    check_eq("b2b_t0_vld2", dout_valid, 1'b0);
    raddr = 1; tick();
    check_eq("b2b_t1_dout1", dout1, 64'h2001);
    check_eq("b2b_t1_vld2", dout_valid, 1'b1);
    check_eq("b2b_t1_dout2", dout, 64'h1000);
    raddr = 2; tick();
    check_eq("b2b_t2_vld1", dout_valid1, 1'b1);
    check_eq("b2b_t2_dout1", dout1, 64'h3002);
    check_eq("b2b_t2_dout2", dout, 64'h2001);
    re = 1'b0; tick();
    check_eq("b2b_t3_vld1", dout_valid1, 1'b0);
    check_eq("b2b_t3_dout2", dout, 64'h3002);
    tick();
    check_eq("b2b_t4_vld2", dout_valid, 1'b0);
    check_eq("b2b_hold_dout", dout, 64'h3002);

    // Reset mid-operation drops in-flight reads and restarts init
    re = 1'b1; raddr = 0; tick();
    raddr = 1; tick();
    re = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("mid_rst_vld", dout_valid, 1'b0);
    check_eq("mid_rst_vld1", dout_valid1, 1'b0);
    check_eq("mid_rst_done", init_done, 1'b0);
    check_eq("mid_rst_cnt", perr_cnt, 16'd0);
    tick();
    check_eq("mid_rst_hold_vld", dout_valid, 1'b0);
    rst_n = 1'b1;
    we = 1'b1; waddr = 2; din = 64'hDEADBEEF; wbe = 8'hFF; re = 1'b1; raddr = 2;
    wait_init(cyc, vcnt);
    we = 1'b0; re = 1'b0; wbe = '0;
    check_eq("reinit_cycles", cyc, 16);
    check_eq("reinit_no_vld", vcnt, 0);
    tick();
    check_eq("reinit_vld_after", dout_valid, 1'b0);
    xfer(0, 0, 0, 0, 0, 1, 2, IV, 0, IV, 0, "reinit_rd2");
    xfer(0, 0, 0, 0, 0, 1, 0, IV, 0, IV, 0, "reinit_rd0");

    // Counter saturation
    xfer(1, 9, 64'h77, 8'h01, 1, 0, 0, 0, 0, 0, 0, "sat_wr");
    re = 1'b1; raddr = 9;
    repeat (65540) @(posedge clk);
    #1;
    re = 1'b0;
    repeat (3) tick();
    check_eq("sat_cnt", perr_cnt, 16'hFFFF);
    check_eq("sat_cnt1", perr_cnt1, 16'hFFFF);
    check_eq("sat_addr", perr_addr, 4'd9);
    check_eq("sat_addr1", perr_addr1, 4'd9);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
